// File: rtl/flag_pc_unit.sv
// Flag register, architectural PC, branch resolution and halt control for the
// WISC-F23 single-cycle core; sits directly after the ALU.
module flag_pc_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [2:0]  FLAG_RESET = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic [2:0]  ccc,
    input  logic [8:0]  imm9,
    input  logic [15:0] br_target,
    input  logic [2:0]  alu_flags,
    input  logic [2:0]  alu_flag_en,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        branch_taken,
    output logic [2:0]  flags_q,
    output logic        halt
);

    localparam logic S_RUN    = 1'b0;
    localparam logic S_HALTED = 1'b1;

    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic        r_state;
    logic [15:0] r_pc;
    logic [2:0]  r_flags;

    logic        w_run;
    logic        w_z;
    logic        w_n;
    logic        w_v;
    logic        w_cond;
    logic        w_is_branch;
    logic        w_taken;
    logic [15:0] w_pc_plus2;
    logic [15:0] w_offset;
    logic [15:0] w_pc_next;
    logic [2:0]  w_flags_next;

    assign w_run       = (r_state == S_RUN);
    assign w_v         = r_flags[0];
    assign w_z         = r_flags[1];
    assign w_n         = r_flags[2];
    assign w_is_branch = (opcode == OP_B) || (opcode == OP_BR);
    assign w_pc_plus2  = r_pc + 16'd2;
    // Sign-extended word offset converted to a byte offset.
    assign w_offset    = {{6{imm9[8]}}, imm9, 1'b0};

    always_comb begin
        w_cond = 1'b0;
        case (ccc)
            3'b000:  w_cond = ~w_z;
            3'b001:  w_cond = w_z;
            3'b010:  w_cond = ~w_z & ~w_n;
            3'b011:  w_cond = w_n;
            3'b100:  w_cond = w_z | (~w_z & ~w_n);
            3'b101:  w_cond = w_n | w_z;
            3'b110:  w_cond = w_v;
            default: w_cond = 1'b1;
        endcase
    end

    assign w_taken = w_run & w_is_branch & w_cond;

    always_comb begin
        w_pc_next = w_pc_plus2;
        if (opcode == OP_HLT) begin
            w_pc_next = r_pc;
        end else if (w_taken && (opcode == OP_B)) begin
            w_pc_next = w_pc_plus2 + w_offset;
        end else if (w_taken && (opcode == OP_BR)) begin
            w_pc_next = br_target;
        end
    end

    always_comb begin
        w_flags_next = r_flags;
        for (int unsigned i = 0; i < 3; i++) begin
            if (alu_flag_en[i]) begin
                w_flags_next[i] = alu_flags[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_pc    <= RESET_PC;
            r_flags <= FLAG_RESET;
        end else if (w_run) begin
            if (opcode == OP_HLT) begin
                r_state <= S_HALTED;
            end else begin
                r_pc    <= w_pc_next;
                r_flags <= w_flags_next;
            end
        end
    end

    assign pc           = r_pc;
    assign pc_plus2     = w_pc_plus2;
    assign branch_taken = w_taken;
    assign flags_q      = r_flags;
    assign halt         = (r_state == S_HALTED);

endmodule
